// File: rtl/rs_add.sv
// rs_add: 4-entry compacting reservation station feeding the add unit.
// Define RS_ADD_WAKEUP_ISSUE_EN to let a CDB wakeup select in its arrival cycle.
module rs_add (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        freeze_back,
  input  logic        valid_dp,
  input  logic [4:0]  Pa_dp,
  input  logic [4:0]  Pb_dp,
  input  logic [4:0]  Pw_dp,
  input  logic        rdy_a_dp,
  input  logic        rdy_b_dp,
  input  logic [4:0]  tag_ROB_dp,
  output logic        ready_dp,
  input  logic        cdb0_valid,
  input  logic [4:0]  cdb0_Pw,
  input  logic        cdb1_valid,
  input  logic [4:0]  cdb1_Pw,
  output logic [4:0]  Pa_rd,
  output logic [4:0]  Pb_rd,
  input  logic [15:0] busA_rd,
  input  logic [15:0] busB_rd,
  output logic        valid_add,
  output logic [4:0]  Pw_add,
  output logic [15:0] busA_add,
  output logic [15:0] busB_add,
  output logic [4:0]  tag_ROB_add
);

  localparam int N = 4;

  logic [2:0]        count_q, count_d;
  logic [N-1:0][4:0] pa_q, pa_d;
  logic [N-1:0][4:0] pb_q, pb_d;
  logic [N-1:0][4:0] pw_q, pw_d;
  logic [N-1:0][4:0] tag_q, tag_d;
  logic [N-1:0]      rdy_a_q, rdy_a_d;
  logic [N-1:0]      rdy_b_q, rdy_b_d;

  logic        valid_add_q, valid_add_d;
  logic [4:0]  pw_add_q, pw_add_d;
  logic [15:0] bus_a_add_q, bus_a_add_d;
  logic [15:0] bus_b_add_q, bus_b_add_d;
  logic [4:0]  tag_add_q, tag_add_d;

  logic [N-1:0] wake_a, wake_b, live, cand;
  logic         sel_vld;
  logic [1:0]   sel_idx;
  logic         dp_acc;
  logic         dp_wake_a, dp_wake_b;
  logic [1:0]   wr_idx;

  assign ready_dp = ~count_q[2];
  assign dp_acc   = valid_dp & ready_dp;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wake_a[i] = (cdb0_valid && cdb0_Pw == pa_q[i]) ||
                  (cdb1_valid && cdb1_Pw == pa_q[i]);
      wake_b[i] = (cdb0_valid && cdb0_Pw == pb_q[i]) ||
                  (cdb1_valid && cdb1_Pw == pb_q[i]);
      live[i]   = 3'(i) < count_q;
`ifdef RS_ADD_WAKEUP_ISSUE_EN
      cand[i]   = live[i] & (rdy_a_q[i] | wake_a[i]) &
                  (rdy_b_q[i] | wake_b[i]);
`else
      cand[i]   = live[i] & rdy_a_q[i] & rdy_b_q[i];
`endif
    end
  end

  // Descending scan so the oldest ready entry wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 2'd0;
    if (!freeze_back && !flush) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (cand[i]) begin
          sel_vld = 1'b1;
          sel_idx = 2'(i);
        end
      end
    end
  end

  assign Pa_rd = pa_q[sel_idx];
  assign Pb_rd = pb_q[sel_idx];

  always_comb begin
    dp_wake_a = (cdb0_valid && cdb0_Pw == Pa_dp) ||
                (cdb1_valid && cdb1_Pw == Pa_dp);
    dp_wake_b = (cdb0_valid && cdb0_Pw == Pb_dp) ||
                (cdb1_valid && cdb1_Pw == Pb_dp);
    wr_idx    = count_q[1:0] - 2'(sel_vld);

    pa_d    = pa_q;
    pb_d    = pb_q;
    pw_d    = pw_q;
    tag_d   = tag_q;
    rdy_a_d = rdy_a_q | wake_a;
    rdy_b_d = rdy_b_q | wake_b;

    // Compact: entries above the issuing slot move down one.
    if (sel_vld) begin
      for (int i = 0; i < N - 1; i++) begin
        if (2'(i) >= sel_idx) begin
          pa_d[i]    = pa_d[i+1];
          pb_d[i]    = pb_d[i+1];
          pw_d[i]    = pw_d[i+1];
          tag_d[i]   = tag_d[i+1];
          rdy_a_d[i] = rdy_a_d[i+1];
          rdy_b_d[i] = rdy_b_d[i+1];
        end
      end
      rdy_a_d[N-1] = 1'b0;
      rdy_b_d[N-1] = 1'b0;
    end

    if (dp_acc) begin
      pa_d[wr_idx]    = Pa_dp;
      pb_d[wr_idx]    = Pb_dp;
      pw_d[wr_idx]    = Pw_dp;
      tag_d[wr_idx]   = tag_ROB_dp;
      rdy_a_d[wr_idx] = rdy_a_dp | dp_wake_a;
      rdy_b_d[wr_idx] = rdy_b_dp | dp_wake_b;
    end

    count_d = count_q + 3'(dp_acc) - 3'(sel_vld);

    if (flush) begin
      count_d = 3'd0;
      rdy_a_d = '0;
      rdy_b_d = '0;
    end
  end

  always_comb begin
    valid_add_d = valid_add_q;
    pw_add_d    = pw_add_q;
    bus_a_add_d = bus_a_add_q;
    bus_b_add_d = bus_b_add_q;
    tag_add_d   = tag_add_q;
    if (flush) begin
      valid_add_d = 1'b0;
    end else if (!freeze_back) begin
      valid_add_d = sel_vld;
      pw_add_d    = pw_q[sel_idx];
      bus_a_add_d = busA_rd;
      bus_b_add_d = busB_rd;
      tag_add_d   = tag_q[sel_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 3'd0;
      pa_q        <= '0;
      pb_q        <= '0;
      pw_q        <= '0;
      tag_q       <= '0;
      rdy_a_q     <= '0;
      rdy_b_q     <= '0;
      valid_add_q <= 1'b0;
      pw_add_q    <= 5'd0;
      bus_a_add_q <= 16'd0;
      bus_b_add_q <= 16'd0;
      tag_add_q   <= 5'd0;
    end else begin
      count_q     <= count_d;
      pa_q        <= pa_d;
      pb_q        <= pb_d;
      pw_q        <= pw_d;
      tag_q       <= tag_d;
      rdy_a_q     <= rdy_a_d;
      rdy_b_q     <= rdy_b_d;
      valid_add_q <= valid_add_d;
      pw_add_q    <= pw_add_d;
      bus_a_add_q <= bus_a_add_d;
      bus_b_add_q <= bus_b_add_d;
      tag_add_q   <= tag_add_d;
    end
  end

  assign valid_add   = valid_add_q;
  assign Pw_add      = pw_add_q;
  assign busA_add    = bus_a_add_q;
  assign busB_add    = bus_b_add_q;
  assign tag_ROB_add = tag_add_q;

endmodule

// File: tb/tb_rs_add.sv
// tb_rs_add: directed bench for rs_add.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rs_add;

`ifdef RS_ADD_WAKEUP_ISSUE_EN
  localparam int WAKE_LAT = 1;
`else
  localparam int WAKE_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, freeze_back, valid_dp;
  logic [4:0]  Pa_dp, Pb_dp, Pw_dp, tag_ROB_dp;
  logic        rdy_a_dp, rdy_b_dp, ready_dp;
  logic        cdb0_valid, cdb1_valid;
  logic [4:0]  cdb0_Pw, cdb1_Pw, Pa_rd, Pb_rd;
  logic [15:0] busA_rd, busB_rd, busA_add, busB_add;
  logic        valid_add;
  logic [4:0]  Pw_add, tag_ROB_add;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;

  rs_add dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
    .valid_dp(valid_dp), .Pa_dp(Pa_dp), .Pb_dp(Pb_dp), .Pw_dp(Pw_dp),
    .rdy_a_dp(rdy_a_dp), .rdy_b_dp(rdy_b_dp), .tag_ROB_dp(tag_ROB_dp),
    .ready_dp(ready_dp),
    .cdb0_valid(cdb0_valid), .cdb0_Pw(cdb0_Pw),
    .cdb1_valid(cdb1_valid), .cdb1_Pw(cdb1_Pw),
    .Pa_rd(Pa_rd), .Pb_rd(Pb_rd), .busA_rd(busA_rd), .busB_rd(busB_rd),
    .valid_add(valid_add), .Pw_add(Pw_add), .busA_add(busA_add),
    .busB_add(busB_add), .tag_ROB_add(tag_ROB_add)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    valid_dp   = 1'b0;
    cdb0_valid = 1'b0;
    cdb1_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic dp(input logic [4:0] a, input logic [4:0] b,
                    input logic [4:0] w, input logic ra, input logic rb,
                    input logic [4:0] t);
    valid_dp   = 1'b1;
    Pa_dp      = a;
    Pb_dp      = b;
    Pw_dp      = w;
    rdy_a_dp   = ra;
    rdy_b_dp   = rb;
    tag_ROB_dp = t;
  endtask

  task automatic cdb(input logic [4:0] p0, input logic [4:0] p1);
    cdb0_valid = 1'b1;
    cdb0_Pw    = p0;
    cdb1_valid = 1'b1;
    cdb1_Pw    = p1;
  endtask

  // Cycles from the wakeup edge until valid_add rises (5 = never).
  task automatic wait_issue(output int n);
    n = 1;
    while (!valid_add && n < 5) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    freeze_back = 1'b0;
    Pa_dp = 0; Pb_dp = 0; Pw_dp = 0; tag_ROB_dp = 0;
    rdy_a_dp = 0; rdy_b_dp = 0;
    cdb0_Pw = 0; cdb1_Pw = 0;
    busA_rd = 16'h0010;
    busB_rd = 16'h0020;

    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready_dp), 1);
    chk("rst_valid", 32'(valid_add), 0);
    chk("rst_pw", 32'(Pw_add), 0);
    chk("rst_busa", 32'(busA_add), 0);
    chk("rst_tag", 32'(tag_ROB_add), 0);
    chk("rst_pa_rd", 32'(Pa_rd), 0);
    cyc(); cyc();
    rst = 1'b0;

    // basic dispatch to issue
    dp(3, 4, 9, 1, 1, 2); cyc(); idle();
    chk("t1_pa_rd", 32'(Pa_rd), 3);
    chk("t1_pb_rd", 32'(Pb_rd), 4);
    chk("t1_early", 32'(valid_add), 0);
    cyc();
    chk("t1_valid", 32'(valid_add), 1);
    chk("t1_pw", 32'(Pw_add), 9);
    chk("t1_busa", 32'(busA_add), 16'h0010);
    chk("t1_busb", 32'(busB_add), 16'h0020);
    chk("t1_tag", 32'(tag_ROB_add), 2);
    cyc();
    chk("t1_drain", 32'(valid_add), 0);

    // fill, refuse, wake middle entry, compaction order
    dp(20, 21, 1, 0, 0, 10); cyc();
    dp(22, 23, 2, 0, 0, 11); cyc();
    dp(12, 12, 3, 0, 0, 12); cyc();
    dp(24, 25, 4, 0, 0, 13); cyc();
    idle();
    chk("full_ready", 32'(ready_dp), 0);
    dp(26, 27, 5, 1, 1, 14); cyc(); idle();
    cdb0_valid = 1'b1; cdb0_Pw = 5'd12;
    cyc(); idle();
    wait_issue(lat);
    chk("e2_valid", 32'(valid_add), 1);
    chk("e2_pw", 32'(Pw_add), 3);
    chk("e2_tag", 32'(tag_ROB_add), 12);
    chk("cnt3_ready", 32'(ready_dp), 1);
    dp(24, 25, 6, 0, 0, 15); cyc(); idle();
    chk("refill_ready", 32'(ready_dp), 0);
    cdb(24, 25); cyc(); idle();
    wait_issue(lat);
    chk("shift_tag", 32'(tag_ROB_add), 13);
    chk("shift_pw", 32'(Pw_add), 4);
    cyc();
    chk("top_valid", 32'(valid_add), 1);
    chk("top_tag", 32'(tag_ROB_add), 15);

    // flush with concurrent dispatch and pending issue
    dp(1, 2, 7, 1, 1, 3); cyc();
    dp(5, 6, 8, 1, 1, 4); flush = 1'b1; cyc(); idle();
    chk("fl_valid", 32'(valid_add), 0);
    chk("fl_ready", 32'(ready_dp), 1);
    cyc();
    chk("fl_none", 32'(valid_add), 0);
    cdb(20, 21); cyc(); idle(); cyc(); cyc();
    chk("fl_gone", 32'(valid_add), 0);

    // oldest first, then freeze hold
    dp(1, 2, 7, 1, 1, 5); cyc();
    dp(3, 4, 8, 1, 1, 6); cyc(); idle();
    chk("fz_first", 32'(tag_ROB_add), 5);
    freeze_back = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("fz_valid", 32'(valid_add), 1);
      chk("fz_tag", 32'(tag_ROB_add), 5);
      chk("fz_pw", 32'(Pw_add), 7);
    end
    freeze_back = 1'b0;
    cyc();
    chk("fz_next", 32'(tag_ROB_add), 6);
    chk("fz_next_pw", 32'(Pw_add), 8);
    cyc();
    chk("fz_drain", 32'(valid_add), 0);

    // dispatch bypass from cdb1
    dp(7, 8, 9, 0, 1, 7); cdb1_valid = 1'b1; cdb1_Pw = 5'd7;
    cyc(); idle(); cyc();
    chk("byp_valid", 32'(valid_add), 1);
    chk("byp_tag", 32'(tag_ROB_add), 7);
    cyc();
    chk("byp_drain", 32'(valid_add), 0);

    // wakeup-to-issue latency
    dp(10, 11, 2, 0, 0, 8); cyc(); idle(); cyc();
    cdb(10, 11); cyc(); idle();
    wait_issue(lat);
    chk("wake_lat", 32'(lat), 32'(WAKE_LAT));
    chk("wake_tag", 32'(tag_ROB_add), 8);
    cyc();
    chk("wake_drain", 32'(valid_add), 0);

    // asynchronous reset mid-stream
    dp(5, 6, 11, 1, 1, 9); cyc();
    dp(1, 2, 3, 0, 0, 1); cyc(); idle();
    chk("pre_rst", 32'(tag_ROB_add), 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_add), 0);
    chk("arst_pw", 32'(Pw_add), 0);
    chk("arst_tag", 32'(tag_ROB_add), 0);
    chk("arst_busa", 32'(busA_add), 0);
    chk("arst_busb", 32'(busB_add), 0);
    chk("arst_ready", 32'(ready_dp), 1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_valid", 32'(valid_add), 0);
    for (int i = 0; i < 3; i++) begin
      dp(5'(16 + i), 5'(16 + i), 1, 0, 0, 5'(i));
      cyc();
    end
    idle();
    chk("post_cnt3", 32'(ready_dp), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
